// File: rtl/pcie_rx_tlp_demux.sv
// Receive-side TLP classifier for the 7-series PCIe RX AXI-stream: routes MRd/MWr
// to the request stream and Cpl/CplD to the completion stream, discards the rest.

module pcie_rx_tlp_fifo #(
  parameter int DATA_W = 82
) (
  input  logic              clk,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              ready,
  output logic              valid,
  output logic              full,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic              pop;

  assign valid = (count != 2'd0);
  assign full  = (count == 2'd2);
  assign pop   = valid & ready;
  // Storage is never cleared, so the payload is masked while the buffer is empty
  assign dout  = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

endmodule

module pcie_rx_tlp_demux #(
  parameter int C_DATA_WIDTH = 64,
  parameter int KEEP_WIDTH   = C_DATA_WIDTH / 8,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    user_clk,
  input  logic                    user_reset,
  input  logic                    user_lnk_up,
  input  logic [C_DATA_WIDTH-1:0] m_axis_rx_tdata,
  input  logic [KEEP_WIDTH-1:0]   m_axis_rx_tkeep,
  input  logic                    m_axis_rx_tlast,
  input  logic                    m_axis_rx_tvalid,
  output logic                    m_axis_rx_tready,
  input  logic [21:0]             m_axis_rx_tuser,
  output logic [C_DATA_WIDTH-1:0] req_tdata,
  output logic [KEEP_WIDTH-1:0]   req_tkeep,
  output logic                    req_tlast,
  output logic                    req_tsof,
  output logic [7:0]              req_bar_hit,
  output logic                    req_tvalid,
  input  logic                    req_tready,
  output logic [C_DATA_WIDTH-1:0] cpl_tdata,
  output logic [KEEP_WIDTH-1:0]   cpl_tkeep,
  output logic                    cpl_tlast,
  output logic                    cpl_tsof,
  output logic                    cpl_tvalid,
  input  logic                    cpl_tready,
  output logic [CNT_WIDTH-1:0]    drop_count,
  output logic [CNT_WIDTH-1:0]    poison_count
);

  localparam int ENTRY_W = C_DATA_WIDTH + KEEP_WIDTH + 10;

  typedef enum logic [1:0] {IDLE, PASS_REQ, PASS_CPL, DROP} state_t;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  state_t             state;
  state_t             state_nxt;
  logic               flush;
  logic               accept;
  logic               sof;
  logic [1:0]         fmt;
  logic [4:0]         typ;
  logic               is_mem;
  logic               is_cpl;
  logic               is_poison;
  logic               req_push;
  logic               cpl_push;
  logic               drop_inc;
  logic               poison_inc;
  logic               req_full;
  logic               cpl_full;
  logic [7:0]         bar_hold;
  logic [7:0]         push_bar;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] req_dout;
  logic [ENTRY_W-1:0] cpl_dout;
  logic [7:0]         cpl_unused_bar;
  logic               unused_tuser;

  assign unused_tuser = ^{m_axis_rx_tuser[21:10], m_axis_rx_tuser[0], cpl_unused_bar};

  assign flush     = user_reset | ~user_lnk_up;
  assign fmt       = m_axis_rx_tdata[30:29];
  assign typ       = m_axis_rx_tdata[28:24];
  assign is_mem    = (typ == 5'b00000);
  assign is_cpl    = (typ == 5'b01010) && ((fmt == 2'b00) || (fmt == 2'b10));
  assign is_poison = m_axis_rx_tdata[14] | m_axis_rx_tuser[1];

  // Ready never looks at tdata, so it is stable while the core holds a beat
  always_comb begin
    m_axis_rx_tready = 1'b0;
    if (user_reset) begin
      m_axis_rx_tready = 1'b0;
    end else if (!user_lnk_up) begin
      m_axis_rx_tready = 1'b1;
    end else begin
      case (state)
        IDLE:     m_axis_rx_tready = ~req_full & ~cpl_full;
        PASS_REQ: m_axis_rx_tready = ~req_full;
        PASS_CPL: m_axis_rx_tready = ~cpl_full;
        DROP:     m_axis_rx_tready = 1'b1;
        default:  m_axis_rx_tready = 1'b0;
      endcase
    end
  end

  assign accept = m_axis_rx_tvalid & m_axis_rx_tready & ~flush;

  always_comb begin
    state_nxt  = state;
    sof        = 1'b0;
    req_push   = 1'b0;
    cpl_push   = 1'b0;
    drop_inc   = 1'b0;
    poison_inc = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          sof = 1'b1;
          if (is_poison) begin
            poison_inc = 1'b1;
            if (!m_axis_rx_tlast) state_nxt = DROP;
          end else if (is_mem) begin
            req_push = 1'b1;
            if (!m_axis_rx_tlast) state_nxt = PASS_REQ;
          end else if (is_cpl) begin
            cpl_push = 1'b1;
            if (!m_axis_rx_tlast) state_nxt = PASS_CPL;
          end else begin
            drop_inc = 1'b1;
            if (!m_axis_rx_tlast) state_nxt = DROP;
          end
        end
      end
      PASS_REQ: begin
        req_push = accept;
        if (accept && m_axis_rx_tlast) state_nxt = IDLE;
      end
      PASS_CPL: begin
        cpl_push = accept;
        if (accept && m_axis_rx_tlast) state_nxt = IDLE;
      end
      DROP: begin
        if (accept && m_axis_rx_tlast) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (flush) state <= IDLE;
    else       state <= state_nxt;
  end

  // bar_hit is captured on the SOF beat and reused for the rest of the TLP
  always_ff @(posedge user_clk) begin
    if (sof) bar_hold <= m_axis_rx_tuser[9:2];
  end

  assign push_bar   = sof ? m_axis_rx_tuser[9:2] : bar_hold;
  assign push_entry = {m_axis_rx_tdata, m_axis_rx_tkeep, m_axis_rx_tlast, sof, push_bar};

  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      drop_count   <= '0;
      poison_count <= '0;
    end else begin
      if (drop_inc)   drop_count   <= sat_inc(drop_count);
      if (poison_inc) poison_count <= sat_inc(poison_count);
    end
  end

  pcie_rx_tlp_fifo #(.DATA_W(ENTRY_W)) u_req_fifo (
    .clk   (user_clk),
    .flush (flush),
    .push  (req_push),
    .din   (push_entry),
    .ready (req_tready),
    .valid (req_tvalid),
    .full  (req_full),
    .dout  (req_dout)
  );

  pcie_rx_tlp_fifo #(.DATA_W(ENTRY_W)) u_cpl_fifo (
    .clk   (user_clk),
    .flush (flush),
    .push  (cpl_push),
    .din   (push_entry),
    .ready (cpl_tready),
    .valid (cpl_tvalid),
    .full  (cpl_full),
    .dout  (cpl_dout)
  );

  assign {req_tdata, req_tkeep, req_tlast, req_tsof, req_bar_hit} = req_dout;
  assign {cpl_tdata, cpl_tkeep, cpl_tlast, cpl_tsof, cpl_unused_bar} = cpl_dout;

endmodule

// File: doc/pcie_rx_tlp_demux.md
# pcie_rx_tlp_demux

Receive-side TLP classifier that sits directly downstream of the 7-series PCIe core's RX AXI-stream port (m_axis_rx_*), in the core's user_clk domain. It parses the first beat of each TLP and routes memory requests (MRd/MWr) to a request stream and completions (Cpl/CplD) to a completion stream. It discards every other TLP type, and any poisoned or error-forwarded TLP, while keeping the core's RX port drained. Each output has a 2-entry buffer so downstream backpressure never corrupts packet order.

## Interface
- C_DATA_WIDTH, 64, RX beat width; only 64 is supported.
- KEEP_WIDTH, C_DATA_WIDTH/8, byte-enable width.
- CNT_WIDTH, 16, width of the saturating statistics counters.

Ports:
- user_clk  in  1  core user clock; the only clock.
- user_reset  in  1  synchronous, active-high reset.
- user_lnk_up  in  1  link-up from the core; low = flush.
- m_axis_rx_tdata  in  C_DATA_WIDTH  RX beat; DW0 = [31:0], DW1 = [63:32].
- m_axis_rx_tkeep  in  KEEP_WIDTH  RX byte keep.
- m_axis_rx_tlast  in  1  last beat of the TLP.
- m_axis_rx_tvalid  in  1  RX beat valid.
- m_axis_rx_tready  out  1  RX beat accepted.
- m_axis_rx_tuser  in  22  [1] err_fwd, [9:2] bar_hit, other bits ignored.
- req_tdata/req_tkeep/req_tlast  out  64/8/1  request stream payload.
- req_tsof  out  1  first beat of the request TLP.
- req_bar_hit  out  8  bar_hit latched at SOF, held for the whole TLP.
- req_tvalid  out  1  request beat valid.
- req_tready  in  1  request beat accepted.
- cpl_tdata/cpl_tkeep/cpl_tlast/cpl_tsof  out  64/8/1/1  completion stream.
- cpl_tvalid  out  1  completion beat valid.
- cpl_tready  in  1  completion beat accepted.
- drop_count  out  CNT_WIDTH  count of unsupported TLPs discarded; saturating.
- poison_count  out  CNT_WIDTH  count of TLPs discarded for EP or err_fwd; saturating.

## Operation
States and transitions:
- IDLE: expects SOF. A beat is accepted when tvalid & tready.
  - Decode from DW0: fmt = [30:29], type = [28:24], EP = [14].
  - MRd/MWr: type 00000, any fmt.
  - Cpl/CplD: type 01010 with fmt 00 or 10.
  - If EP = 1 or tuser[1] = 1: poison_count increments; go to DROP.
  - Else if the TLP is neither MRd/MWr nor Cpl/CplD: drop_count increments; go to DROP.
  - Else: the beat is pushed to the class FIFO with tsof = 1 and bar_hit latched; go to PASS_REQ or PASS_CPL.
  - If tlast is set on the SOF beat, the TLP still goes to the FIFO or is counted, but the state stays IDLE.
- PASS_REQ / PASS_CPL: each accepted beat is pushed to the class FIFO with tsof = 0. Return to IDLE on an accepted tlast.
- DROP: beats are consumed and discarded. Return to IDLE on an accepted tlast.

Ready rules:
- IDLE: m_axis_rx_tready = req FIFO not full AND cpl FIFO not full. It does not depend on tdata.
- PASS_x: m_axis_rx_tready = that class's FIFO not full.
- DROP: m_axis_rx_tready = 1.

Buffering and counters:
- Each FIFO is 2 entries. Push and pop in the same cycle is legal and leaves the count unchanged; pushing when full cannot occur because of the ready rules.
- Counters saturate at all-ones, with no wrap.

Flush (user_reset = 1, or user_lnk_up = 0):
- Next cycle: both FIFOs empty, state IDLE.
- user_lnk_up = 0 holds m_axis_rx_tready = 1 and discards input.
- Counters clear only on user_reset.
- Reset mid-packet abandons that TLP; the next beat seen is treated as SOF.

## Timing
- Reset values: all tvalid = 0, m_axis_rx_tready = 0 during the reset cycle, tsof = 0, bar_hit = 0, tdata/tkeep = 0, counters = 0, state = IDLE.
- Latency: a beat accepted at edge N is presented on the output (tvalid = 1) after edge N, i.e. one cycle later when the FIFO was empty.
- Throughput: 1 beat per cycle with an always-ready sink.
- Output handshake: tvalid, once asserted, holds with stable payload until tready. Beats leave in arrival order per class.
- Counter updates are visible the cycle after the SOF beat is accepted.

## Test plan
- MWr 3DW + 1 data DW: beat0 = 0x00000000_40000001 with bar_hit = 0x01, beat1 = tlast. Required: req_tvalid one cycle after each acceptance, req_tsof = 1 on beat0 only, req_bar_hit = 0x01 on both beats, cpl_tvalid stays 0.
- CplD with DW0 = 0x4A000001, 2 beats. Required: appears on cpl only, cpl_tsof on the first beat, 2 beats, cpl_tlast on the second.
- Msg with DW0 = 0x34000000, 2 beats. Required: m_axis_rx_tready = 1 on both beats, no output valid, drop_count = 1.
- MWr with tdata[14] = 1, then a separate TLP with tuser[1] = 1. Required: both discarded, poison_count = 2, drop_count = 0.
- 4-beat MWr with req_tready = 0. Required: m_axis_rx_tready falls after 2 beats are buffered. Raise req_tready: all 4 beats delivered in order with no duplicates, and a following CplD is accepted after the MWr tlast.
- user_reset for 1 cycle after beat1 of a 3-beat MWr. Required: req_tvalid = 0 and counters = 0 the next cycle; a new CplD then routes correctly. Repeat with user_lnk_up = 0 mid-packet: FIFOs flushed and counters preserved.
